// File: rtl/emio_pkg.sv
// emio_pkg: EMIO control bit offsets, bridge FSM states and width limits shared by the EMIO bridge
package emio_pkg;
    localparam int EMIO_MAX_W = 64;
    localparam int OFS_REQ    = 0;
    localparam int OFS_DONE   = 1;
    localparam int OFS_WEN    = 2;
    localparam int OFS_WSTART = 3;
    localparam int OFS_BLKWEN = 4;
    localparam int OFS_ISWR   = 5;
    localparam int OFS_GRANT  = 6;
    localparam int OFS_RT     = 7;
    localparam int OFS_ERR    = 8;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RT_RD,
        S_WR_WAIT,
        S_WR_BLK,
        S_DONE,
        S_ERR
    } bridge_state_t;
    function automatic int emio_w(input int data_w, input int addr_w);
        return data_w + addr_w + OFS_ERR + 1;
    endfunction
endpackage

// File: rtl/emio_req_sync.sv
// emio_req_sync: synchronises the PS request level into sysclk and flags its rising and falling edges
module emio_req_sync #(
    parameter int SYNC_N = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [SYNC_N-1:0] sync_q;
    logic              prev_q;
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], d};
            prev_q <= sync_q[SYNC_N-1];
        end
    end
    assign rise = sync_q[SYNC_N-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_N-1] & prev_q;
endmodule

// File: rtl/emio_bus_bridge.sv
// emio_bus_bridge: PS<->FPGA register bridge over the Zynq EMIO bus with bus arbitration and grant/valid timeout
module emio_bus_bridge
    import emio_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int SYNC_N  = 2,
    parameter int TMO_CYC = 1023
) (
    input  logic              sysclk,
    input  logic              reset,
    output logic [63:0]       emio_ps_in,
    input  logic [63:0]       emio_ps_out,
    input  logic [63:0]       emio_ps_tri,
    output logic [ADDR_W-1:0] reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              req_read_bus,
    input  logic              grant_read_bus,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wen,
    output logic              blk_wstart,
    output logic              blk_wen,
    output logic              req_blk_rt_rd,
    output logic              blk_rt_rd,
    output logic              req_write_bus,
    input  logic              grant_write_bus,
    output logic              err_tmo
);
    localparam int C      = DATA_W + ADDR_W;
    localparam int EMIO_W = emio_w(DATA_W, ADDR_W);
    localparam int CW     = TMO_CYC < 2 ? 1 : $clog2(TMO_CYC + 1);
    if (EMIO_W > EMIO_MAX_W) begin : g_width_chk
        $error("emio_bus_bridge: EMIO_W exceeds 64 bits");
    end
    if (SYNC_N < 2 || SYNC_N > 4) begin : g_sync_chk
        $error("emio_bus_bridge: SYNC_N must be 2..4");
    end
    bridge_state_t     state, state_n;
    logic              rise, fall, is_write, rt, rd_hit, counting, tmo_evt, tmo_hit;
    logic              done, done_n, is_blk, blk_n, err_n, rd_n, wr_n, rt_n, rtp_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic [CW-1:0]     tmo_cnt, cnt_n;
    logic              unused_bits;
    emio_req_sync #(.SYNC_N(SYNC_N)) u_req_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .d      (emio_ps_out[C+OFS_REQ]),
        .rise   (rise),
        .fall   (fall)
    );
    assign reg_raddr   = emio_ps_out[C-1:DATA_W];
    assign reg_waddr   = emio_ps_out[C-1:DATA_W];
    assign reg_wdata   = emio_ps_out[DATA_W-1:0];
    assign reg_wen     = emio_ps_out[C+OFS_WEN];
    assign blk_wstart  = emio_ps_out[C+OFS_WSTART];
    assign blk_wen     = emio_ps_out[C+OFS_BLKWEN];
    assign rt          = emio_ps_out[C+OFS_RT];
    assign is_write    = ~|emio_ps_tri[DATA_W-1:0];
    assign unused_bits = ^{emio_ps_tri[63:DATA_W], emio_ps_out[63:C+OFS_ERR],
                           emio_ps_out[C+OFS_GRANT:C+OFS_ISWR], emio_ps_out[C+OFS_DONE]};
    assign rd_hit   = grant_read_bus & reg_rvalid;
    assign counting = state == S_RD_WAIT || state == S_WR_WAIT || (state == S_RT_RD && !done);
    assign tmo_evt  = state == S_WR_WAIT ? grant_write_bus : rd_hit;
    assign tmo_hit  = TMO_CYC != 0 && tmo_cnt == CW'(TMO_CYC - 1);
    always_comb begin
        emio_ps_in                 = '0;
        emio_ps_in[DATA_W-1:0]     = is_write ? reg_wdata : rdata_q;
        emio_ps_in[C-1:DATA_W]     = reg_raddr;
        emio_ps_in[C+OFS_REQ]      = emio_ps_out[C+OFS_REQ];
        emio_ps_in[C+OFS_DONE]     = done;
        emio_ps_in[C+OFS_WEN]      = reg_wen;
        emio_ps_in[C+OFS_WSTART]   = blk_wstart;
        emio_ps_in[C+OFS_BLKWEN]   = blk_wen;
        emio_ps_in[C+OFS_ISWR]     = is_write;
        emio_ps_in[C+OFS_GRANT]    = is_write ? grant_write_bus : grant_read_bus;
        emio_ps_in[C+OFS_ERR]      = err_tmo;
    end
    always_comb begin
        state_n = state;
        rd_n    = req_read_bus;
        wr_n    = req_write_bus;
        rt_n    = blk_rt_rd;
        rtp_n   = 1'b0;
        done_n  = done;
        rdata_n = rdata_q;
        blk_n   = is_blk;
        err_n   = err_tmo;
        cnt_n   = '0;
        if (state != S_IDLE && fall) begin
            state_n = S_IDLE;
            rd_n    = 1'b0;
            wr_n    = 1'b0;
            rt_n    = 1'b0;
            done_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE: if (rise) begin
                    err_n = 1'b0;
                    if (is_write) begin
                        wr_n    = 1'b1;
                        blk_n   = blk_wstart;
                        state_n = S_WR_WAIT;
                    end else begin
                        rd_n    = 1'b1;
                        rt_n    = rt;
                        rtp_n   = rt;
                        state_n = rt ? S_RT_RD : S_RD_WAIT;
                    end
                end
                S_RD_WAIT: if (rd_hit) begin
                    rdata_n = reg_rdata;
                    done_n  = 1'b1;
                    rd_n    = 1'b0;
                    state_n = S_DONE;
                end
                S_RT_RD: if (rd_hit) begin
                    rdata_n = reg_rdata;
                    done_n  = 1'b1;
                end
                S_WR_WAIT: if (grant_write_bus) begin
                    done_n  = reg_wen;
                    wr_n    = is_blk;
                    state_n = is_blk ? S_WR_BLK : S_DONE;
                end
                default: ;
            endcase
            if (counting && !tmo_evt) begin
                if (tmo_hit) begin
                    state_n = S_ERR;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    rt_n    = 1'b0;
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = tmo_cnt + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            req_read_bus  <= 1'b0;
            req_write_bus <= 1'b0;
            blk_rt_rd     <= 1'b0;
            req_blk_rt_rd <= 1'b0;
            done          <= 1'b0;
            rdata_q       <= '0;
            is_blk        <= 1'b0;
            err_tmo       <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            state         <= state_n;
            req_read_bus  <= rd_n;
            req_write_bus <= wr_n;
            blk_rt_rd     <= rt_n;
            req_blk_rt_rd <= rtp_n;
            done          <= done_n;
            rdata_q       <= rdata_n;
            is_blk        <= blk_n;
            err_tmo       <= err_n;
            tmo_cnt       <= cnt_n;
        end
    end
endmodule
